// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the fetch/EX memory bus arbiter.
// Holds the FSM and size encodings plus width and size helper functions.
package mem_bus_arbiter_pkg;

  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;

  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int DEFAULT_TIMEOUT      = 255;
  localparam int TIMEOUT_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_RESP   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } mem_size_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_EX = 1'b1
  } owner_t;

  function automatic int addr_width(input int xlen);
    return 1 << (xlen + 4);
  endfunction

  // Fetch always moves a full machine word.
  function automatic logic [1:0] fetch_size(input int aw);
    return (aw == 64) ? 2'(SIZE_DWORD) : 2'(SIZE_WORD);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side ports (fetch, EX, stalls) and the bus command/response
// channel of the arbiter; master is the arbiter, slave is its surroundings.
interface mem_bus_arbiter_if #(
  parameter int AW = 64
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [AW-1:0] if_rdata;
  logic          if_done;
  logic          if_err;

  logic          ex_req;
  logic          ex_we;
  logic [AW-1:0] ex_addr;
  logic [AW-1:0] ex_wdata;
  logic [1:0]    ex_size;
  logic [AW-1:0] ex_rdata;
  logic          ex_done;
  logic          ex_err;

  logic          bus_valid;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [AW-1:0] bus_wdata;
  logic [1:0]    bus_size;
  logic          bus_ready;
  logic          bus_rvalid;
  logic [AW-1:0] bus_rdata;
  logic          bus_err;

  logic          stall_f;
  logic          stall_m;

  modport master (
    input  if_req, if_addr,
    input  ex_req, ex_we, ex_addr, ex_wdata, ex_size,
    input  bus_ready, bus_rvalid, bus_rdata, bus_err,
    output if_rdata, if_done, if_err,
    output ex_rdata, ex_done, ex_err,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_size,
    output stall_f, stall_m
  );

  modport slave (
    output if_req, if_addr,
    output ex_req, ex_we, ex_addr, ex_wdata, ex_size,
    output bus_ready, bus_rvalid, bus_rdata, bus_err,
    input  if_rdata, if_done, if_err,
    input  ex_rdata, ex_done, ex_err,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_size,
    input  stall_f, stall_m
  );

endinterface

// File: rtl/mem_bus_arbiter_timeout_counter.sv
// Cycle counter that flags the last cycle an access may spend waiting on the bus.
// terminal rises during the TIMEOUT-th counted cycle so the abort lands right after it.
module mem_arb_timeout_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  assign terminal = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory bus between fetch and EX load/store,
// with EX priority, a fetch starvation guard and a per-access timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_64B,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.master bus
);

  localparam int            AW         = addr_width(XLEN);
  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0]    FETCH_SIZE = fetch_size(AW);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state;
  owner_t        owner;
  logic [SW-1:0] starve;

  logic          any_req;
  logic          ex_wins;
  logic          to_clear;
  logic          to_enable;
  logic          to_terminal;
  logic          finish;
  logic          fin_err;
  logic [AW-1:0] fin_data;

  assign any_req   = bus.if_req | bus.ex_req;
  assign ex_wins   = bus.ex_req & ~((starve == STARVE_MAX) & bus.if_req);
  assign to_clear  = (state == ST_IDLE);
  assign to_enable = (state == ST_ACCEPT) | (state == ST_RESP);

  assign bus.stall_f = bus.if_req & ~bus.if_done;
  assign bus.stall_m = bus.ex_req & ~bus.ex_done;

  mem_arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (to_clear),
    .enable   (to_enable),
    .terminal (to_terminal)
  );

  // A real response beats a timeout landing in the same cycle; an abort returns zero data.
  always_comb begin
    finish   = 1'b0;
    fin_err  = 1'b1;
    fin_data = '0;
    case (state)
      ST_ACCEPT: finish = to_terminal;
      ST_RESP: begin
        if (bus.bus_rvalid) begin
          finish   = 1'b1;
          fin_err  = bus.bus_err;
          fin_data = bus.bus_rdata;
        end else begin
          finish = to_terminal;
        end
      end
      default: finish = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      owner         <= OWNER_IF;
      starve        <= '0;
      bus.bus_valid <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_size  <= '0;
      bus.if_rdata  <= '0;
      bus.if_done   <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.ex_rdata  <= '0;
      bus.ex_done   <= 1'b0;
      bus.ex_err    <= 1'b0;
    end else begin
      bus.if_done <= 1'b0;
      bus.ex_done <= 1'b0;
      bus.if_err  <= 1'b0;
      bus.ex_err  <= 1'b0;

      if (finish) begin
        if (owner == OWNER_EX) begin
          bus.ex_done  <= 1'b1;
          bus.ex_err   <= fin_err;
          bus.ex_rdata <= fin_data;
        end else begin
          bus.if_done  <= 1'b1;
          bus.if_err   <= fin_err;
          bus.if_rdata <= fin_data;
        end
      end

      case (state)
        ST_IDLE: begin
          if (!bus.if_req) begin
            starve <= '0;
          end
          if (any_req) begin
            state         <= ST_ACCEPT;
            bus.bus_valid <= 1'b1;
            if (ex_wins) begin
              owner         <= OWNER_EX;
              bus.bus_we    <= bus.ex_we;
              bus.bus_addr  <= bus.ex_addr;
              bus.bus_wdata <= bus.ex_wdata;
              bus.bus_size  <= bus.ex_size;
              if (bus.if_req && (starve != STARVE_MAX)) begin
                starve <= starve + 1'b1;
              end
            end else begin
              owner         <= OWNER_IF;
              bus.bus_we    <= 1'b0;
              bus.bus_addr  <= bus.if_addr;
              bus.bus_wdata <= '0;
              bus.bus_size  <= FETCH_SIZE;
              starve        <= '0;
            end
          end
        end
        ST_ACCEPT: begin
          if (finish) begin
            bus.bus_valid <= 1'b0;
            state         <= ST_DONE;
          end else if (bus.bus_ready) begin
            bus.bus_valid <= 1'b0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (finish) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
